// File: rtl/mak8_i2c_target.sv
// mak8_i2c_target: I2C target exposing an 8-bit-addressed register port
// (pointer byte, then write data or read data with auto-increment).
// SCL is sampled only; no clock stretching.
module mak8_i2c_target #(
   parameter logic [6:0] DEV_ADDR    = 7'h42,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       reg_we,
   input  logic [7:0] reg_rdata,
   output logic       busy
);

   // Depth below 2 is not a safe synchronizer, so clamp it.
   localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE
   } state_t;

   logic [NS-1:0] scl_sync_reg;
   logic [NS-1:0] sda_sync_reg;
   logic          scl_hist_reg;
   logic          sda_hist_reg;
   logic          scl_s;
   logic          sda_s;
   logic          scl_rise;
   logic          scl_fall;
   logic          start_det;
   logic          stop_det;

   state_t        state_reg, state_next;
   logic [2:0]    cnt_reg, cnt_next;
   logic [7:0]    shift_reg, shift_next;
   logic          rw_reg, rw_next;
   logic          phase_reg, phase_next;
   logic          sda_oe_reg, sda_oe_next;
   logic          busy_reg, busy_next;
   logic [7:0]    addr_reg, addr_next;
   logic [7:0]    wdata_reg, wdata_next;
   logic          we_reg, we_next;
   logic [7:0]    rx_byte;

   // Synchronize the raw pins and keep one history flop for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync_reg <= '1;
         sda_sync_reg <= '1;
         scl_hist_reg <= 1'b1;
         sda_hist_reg <= 1'b1;
      end else begin
         scl_sync_reg <= {scl_sync_reg[NS-2:0], scl_in};
         sda_sync_reg <= {sda_sync_reg[NS-2:0], sda_in};
         scl_hist_reg <= scl_sync_reg[NS-1];
         sda_hist_reg <= sda_sync_reg[NS-1];
      end
   end

   assign scl_s     = scl_sync_reg[NS-1];
   assign sda_s     = sda_sync_reg[NS-1];
   assign scl_rise  = scl_s & ~scl_hist_reg;
   assign scl_fall  = ~scl_s & scl_hist_reg;
   // SDA moving while SCL stays high marks a bus condition, never a data bit.
   assign start_det = scl_s & scl_hist_reg & sda_hist_reg & ~sda_s;
   assign stop_det  = scl_s & scl_hist_reg & ~sda_hist_reg & sda_s;
   assign rx_byte   = {shift_reg[6:0], sda_s};

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         cnt_reg    <= 3'd0;
         shift_reg  <= 8'h00;
         rw_reg     <= 1'b0;
         phase_reg  <= 1'b0;
         sda_oe_reg <= 1'b0;
         busy_reg   <= 1'b0;
         addr_reg   <= 8'h00;
         wdata_reg  <= 8'h00;
         we_reg     <= 1'b0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         shift_reg  <= shift_next;
         rw_reg     <= rw_next;
         phase_reg  <= phase_next;
         sda_oe_reg <= sda_oe_next;
         busy_reg   <= busy_next;
         addr_reg   <= addr_next;
         wdata_reg  <= wdata_next;
         we_reg     <= we_next;
      end
   end

   // Next-state logic: bus conditions first, then per-state bit handling.
   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      shift_next  = shift_reg;
      rw_next     = rw_reg;
      phase_next  = phase_reg;
      sda_oe_next = sda_oe_reg;
      busy_next   = busy_reg;
      addr_next   = addr_reg;
      wdata_next  = wdata_reg;
      we_next     = 1'b0;

      // The pointer advances the cycle after a write strobe.
      if (we_reg) addr_next = addr_reg + 8'd1;

      if (stop_det) begin
         state_next  = IDLE;
         cnt_next    = 3'd0;
         phase_next  = 1'b0;
         sda_oe_next = 1'b0;
         busy_next   = 1'b0;
      end else if (start_det) begin
         state_next  = ADDR;
         cnt_next    = 3'd0;
         phase_next  = 1'b0;
         sda_oe_next = 1'b0;
      end else begin
         case (state_reg)
            ADDR, PTR, WDATA: begin
               if (scl_rise) begin
                  shift_next = rx_byte;
                  cnt_next   = cnt_reg + 3'd1;
                  if (cnt_reg == 3'd7) begin
                     if (state_reg == ADDR) begin
                        if (rx_byte[7:1] == DEV_ADDR) begin
                           rw_next    = rx_byte[0];
                           state_next = ADDR_ACK;
                        end else begin
                           state_next = IGNORE;
                           busy_next  = 1'b0;
                        end
                     end else if (state_reg == PTR) begin
                        addr_next  = rx_byte;
                        state_next = PTR_ACK;
                     end else begin
                        wdata_next = rx_byte;
                        we_next    = 1'b1;
                        state_next = WDATA_ACK;
                     end
                  end
               end
            end
            ADDR_ACK, PTR_ACK, WDATA_ACK: begin
               // First falling edge pulls SDA low, the second ends the ACK slot.
               if (scl_fall) begin
                  if (!phase_reg) begin
                     phase_next  = 1'b1;
                     sda_oe_next = 1'b1;
                     if (state_reg == ADDR_ACK) busy_next = 1'b1;
                  end else begin
                     phase_next = 1'b0;
                     cnt_next   = 3'd0;
                     if (state_reg == ADDR_ACK && rw_reg) begin
                        shift_next  = {reg_rdata[6:0], 1'b0};
                        sda_oe_next = ~reg_rdata[7];
                        state_next  = RDATA;
                     end else begin
                        sda_oe_next = 1'b0;
                        state_next  = (state_reg == ADDR_ACK) ? PTR : WDATA;
                     end
                  end
               end
            end
            RDATA: begin
               // Bit 7 is already on the bus; cnt counts further bits driven.
               if (scl_fall) begin
                  if (cnt_reg == 3'd7) begin
                     sda_oe_next = 1'b0;
                     cnt_next    = 3'd0;
                     phase_next  = 1'b0;
                     state_next  = RACK;
                  end else begin
                     sda_oe_next = ~shift_reg[7];
                     shift_next  = {shift_reg[6:0], 1'b0};
                     cnt_next    = cnt_reg + 3'd1;
                  end
               end
            end
            RACK: begin
               if (scl_rise && !phase_reg) begin
                  addr_next = addr_reg + 8'd1;
                  if (sda_s) begin
                     state_next = IGNORE;
                     busy_next  = 1'b0;
                  end else begin
                     phase_next = 1'b1;
                  end
               end else if (scl_fall && phase_reg) begin
                  phase_next  = 1'b0;
                  cnt_next    = 3'd0;
                  shift_next  = {reg_rdata[6:0], 1'b0};
                  sda_oe_next = ~reg_rdata[7];
                  state_next  = RDATA;
               end
            end
            default: ;
         endcase
      end
   end

   assign sda_oe    = sda_oe_reg;
   assign reg_addr  = addr_reg;
   assign reg_wdata = wdata_reg;
   assign reg_we    = we_reg;
   assign busy      = busy_reg;

endmodule

// File: tb/tb_mak8_i2c_target.sv
// tb_mak8_i2c_target: bit-banged I2C initiator driving the target, with a
// register-space model predicting write strobes, pointer and read data.
`timescale 1ns/1ps
module tb_mak8_i2c_target;

   localparam int Q = 8;   // quarter SCL period in clk cycles

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       scl_drv = 1'b1;
   logic       sda_drv = 1'b1;
   logic       sda_bus;
   logic       sda_oe;
   logic       reg_we;
   logic       busy;
   logic [7:0] reg_addr;
   logic [7:0] reg_wdata;
   logic [7:0] reg_rdata;

   int checks = 0;
   int failures = 0;
   logic [15:0] we_q[$];
   int oe_cnt = 0;
   int busy_cnt = 0;

   typedef struct {
      logic [7:0] ab;
      logic [7:0] ptr;
      int         nd;
      logic [7:0] d0;
      logic [7:0] d1;
      logic       ack_exp;
      int         nwe;
      logic [7:0] a0;
      logic [7:0] v0;
      logic [7:0] a1;
      logic [7:0] v1;
      logic [7:0] fin;
   } wvec_t;
   wvec_t tbl[3];

   always #5 clk = ~clk;

   // Open-drain bus and a parent whose registers read back as ~address.
   assign sda_bus   = sda_drv & ~sda_oe;
   assign reg_rdata = reg_addr ^ 8'hFF;

   mak8_i2c_target #(.DEV_ADDR(7'h42), .SYNC_STAGES(2)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .scl_in   (scl_drv),
      .sda_in   (sda_bus),
      .sda_oe   (sda_oe),
      .reg_addr (reg_addr),
      .reg_wdata(reg_wdata),
      .reg_we   (reg_we),
      .reg_rdata(reg_rdata),
      .busy     (busy)
   );

   // Record write strobes and activity of sda_oe / busy.
   always @(negedge clk) begin
      if (reg_we) we_q.push_back({reg_addr, reg_wdata});
      if (sda_oe) oe_cnt <= oe_cnt + 1;
      if (busy) busy_cnt <= busy_cnt + 1;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_we(input string name, input int idx, input logic [7:0] a, input logic [7:0] d);
      if (idx < we_q.size()) begin
         check({name, " we_addr"}, int'(we_q[idx][15:8]), int'(a));
         check({name, " we_data"}, int'(we_q[idx][7:0]), int'(d));
      end else begin
         checks++;
         failures++;
         $display("FAIL %s: got no write strobe expected addr %0h data %0h", name, a, d);
      end
   endtask

   task automatic qw();
      repeat (Q) @(negedge clk);
   endtask

   task automatic i2c_start();
      sda_drv = 1'b1; qw();
      scl_drv = 1'b1; qw();
      sda_drv = 1'b0; qw();
      scl_drv = 1'b0; qw();
   endtask

   task automatic i2c_stop();
      sda_drv = 1'b0; qw();
      scl_drv = 1'b1; qw();
      sda_drv = 1'b1; qw();
      qw();
   endtask

   task automatic put_bit(input logic b);
      sda_drv = b; qw();
      scl_drv = 1'b1; qw(); qw();
      scl_drv = 1'b0; qw();
   endtask

   task automatic get_bit(output logic b);
      sda_drv = 1'b1; qw();
      scl_drv = 1'b1; qw();
      b = sda_bus; qw();
      scl_drv = 1'b0; qw();
   endtask

   task automatic put_byte(input logic [7:0] v, output logic ack);
      for (int i = 7; i >= 0; i--) put_bit(v[i]);
      get_bit(ack);
   endtask

   task automatic get_byte(output logic [7:0] v, input logic nack);
      logic b;
      v = 8'h00;
      for (int i = 0; i < 8; i++) begin
         get_bit(b);
         v = {v[6:0], b};
      end
      put_bit(nack);
   endtask

   logic       ack;
   logic [7:0] d;
   logic [7:0] mptr;
   logic [7:0] ab;
   logic [6:0] ab7;
   logic [7:0] ptr;
   logic       matched;
   logic [7:0] exp_a[4];
   logic [7:0] exp_d[4];
   int         wb, oe0, bz0, nd, n, op;

   initial begin
      tbl[0] = '{8'h84, 8'h10, 2, 8'hA5, 8'h3C, 1'b0, 2, 8'h10, 8'hA5, 8'h11, 8'h3C, 8'h12};
      tbl[1] = '{8'h90, 8'h55, 0, 8'h00, 8'h00, 1'b1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h12};
      tbl[2] = '{8'h84, 8'hFF, 2, 8'h11, 8'h22, 1'b0, 2, 8'hFF, 8'h11, 8'h00, 8'h22, 8'h01};

      // Reset state
      repeat (4) @(negedge clk);
      check("reset sda_oe", int'(sda_oe), 0);
      check("reset reg_we", int'(reg_we), 0);
      check("reset busy", int'(busy), 0);
      check("reset reg_addr", int'(reg_addr), 8'h00);
      check("reset reg_wdata", int'(reg_wdata), 8'h00);
      rst_n = 1'b1;
      qw();

      // Table-driven write transactions
      for (int t = 0; t < 3; t++) begin
         wb = we_q.size(); oe0 = oe_cnt; bz0 = busy_cnt;
         i2c_start();
         put_byte(tbl[t].ab, ack);
         check("tbl addr ack", int'(ack), int'(tbl[t].ack_exp));
         put_byte(tbl[t].ptr, ack);
         check("tbl ptr ack", int'(ack), int'(tbl[t].ack_exp));
         for (int k = 0; k < tbl[t].nd; k++) begin
            d = (k == 0) ? tbl[t].d0 : tbl[t].d1;
            put_byte(d, ack);
            check("tbl data ack", int'(ack), int'(tbl[t].ack_exp));
         end
         i2c_stop();
         check("tbl we count", we_q.size() - wb, tbl[t].nwe);
         if (tbl[t].nwe > 0) check_we("tbl first", wb, tbl[t].a0, tbl[t].v0);
         if (tbl[t].nwe > 1) check_we("tbl second", wb + 1, tbl[t].a1, tbl[t].v1);
         check("tbl reg_addr", int'(reg_addr), int'(tbl[t].fin));
         check("tbl busy after stop", int'(busy), 0);
         check("tbl sda_oe activity", int'(oe_cnt != oe0), int'(!tbl[t].ack_exp));
         check("tbl busy activity", int'(busy_cnt != bz0), int'(!tbl[t].ack_exp));
         $display("txn table %0d: addr=%02h ptr=%02h bytes=%0d reg_addr=%02h", t, tbl[t].ab, tbl[t].ptr, tbl[t].nd, reg_addr);
      end

      // Combined read with repeated START
      wb = we_q.size();
      i2c_start();
      put_byte(8'h84, ack); check("cr addr ack", int'(ack), 0);
      put_byte(8'h20, ack); check("cr ptr ack", int'(ack), 0);
      i2c_start();
      put_byte(8'h85, ack); check("cr raddr ack", int'(ack), 0);
      check("cr busy", int'(busy), 1);
      get_byte(d, 1'b0); check("cr byte0", int'(d), 8'hDF);
      get_byte(d, 1'b1); check("cr byte1", int'(d), 8'hDE);
      i2c_stop();
      check("cr no we", we_q.size() - wb, 0);
      check("cr reg_addr", int'(reg_addr), 8'h22);
      check("cr busy after", int'(busy), 0);
      $display("txn combined read: reg_addr=%02h", reg_addr);

      // Abort mid-byte with STOP
      wb = we_q.size();
      i2c_start();
      put_byte(8'h84, ack); check("ab addr ack", int'(ack), 0);
      put_byte(8'h30, ack); check("ab ptr ack", int'(ack), 0);
      put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b1);
      i2c_stop();
      check("ab no we", we_q.size() - wb, 0);
      check("ab reg_addr", int'(reg_addr), 8'h30);
      check("ab sda_oe", int'(sda_oe), 0);
      check("ab busy", int'(busy), 0);
      i2c_start();
      put_byte(8'h84, ack); check("ab2 addr ack", int'(ack), 0);
      put_byte(8'h40, ack); check("ab2 ptr ack", int'(ack), 0);
      put_byte(8'h5A, ack); check("ab2 data ack", int'(ack), 0);
      i2c_stop();
      check("ab2 we count", we_q.size() - wb, 1);
      check_we("ab2", wb, 8'h40, 8'h5A);
      check("ab2 reg_addr", int'(reg_addr), 8'h41);
      $display("txn abort+rewrite: reg_addr=%02h", reg_addr);

      // Async reset while the target drives a 0 data bit
      i2c_start();
      put_byte(8'h84, ack); check("rst addr ack", int'(ack), 0);
      put_byte(8'h80, ack); check("rst ptr ack", int'(ack), 0);
      i2c_start();
      put_byte(8'h85, ack); check("rst raddr ack", int'(ack), 0);
      check("rst driving bit7", int'(sda_oe), 1);
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("rst sda_oe async", int'(sda_oe), 0);
      check("rst reg_addr async", int'(reg_addr), 8'h00);
      check("rst busy async", int'(busy), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      wb = we_q.size(); oe0 = oe_cnt; bz0 = busy_cnt;
      get_byte(d, 1'b1);
      i2c_stop();
      check("rst ignored byte", int'(d), 8'hFF);
      check("rst no oe", oe_cnt - oe0, 0);
      check("rst no busy", busy_cnt - bz0, 0);
      check("rst no we", we_q.size() - wb, 0);
      i2c_start();
      put_byte(8'h84, ack); check("rst2 addr ack", int'(ack), 0);
      put_byte(8'h07, ack); check("rst2 ptr ack", int'(ack), 0);
      put_byte(8'h99, ack); check("rst2 data ack", int'(ack), 0);
      i2c_stop();
      check_we("rst2", wb, 8'h07, 8'h99);
      check("rst2 reg_addr", int'(reg_addr), 8'h08);
      $display("txn async reset: reg_addr=%02h", reg_addr);

      // Randomized transactions against the register-space model
      mptr = 8'h08;
      for (int it = 0; it < 14; it++) begin
         op = $urandom_range(0, 2);
         wb = we_q.size();
         if (op != 2) begin
            matched = ($urandom_range(0, 3) != 0);
            if (matched) ab = 8'h84;
            else begin
               ab7 = 7'($urandom_range(0, 127));
               if (ab7 == 7'h42) ab7 = 7'h43;
               ab = {ab7, 1'($urandom_range(0, 1))};
            end
            ptr = 8'($urandom_range(0, 255));
            nd = $urandom_range(0, 3);
            if (matched) mptr = ptr;
            i2c_start();
            put_byte(ab, ack); check("rnd addr ack", int'(ack), int'(!matched));
            put_byte(ptr, ack); check("rnd ptr ack", int'(ack), int'(!matched));
            for (int k = 0; k < nd; k++) begin
               d = 8'($urandom_range(0, 255));
               if (matched) begin
                  exp_a[k] = mptr;
                  exp_d[k] = d;
                  mptr = mptr + 8'd1;
               end
               put_byte(d, ack); check("rnd data ack", int'(ack), int'(!matched));
            end
            i2c_stop();
            check("rnd we count", we_q.size() - wb, matched ? nd : 0);
            if (matched) for (int k = 0; k < nd; k++) check_we("rnd", wb + k, exp_a[k], exp_d[k]);
            check("rnd reg_addr", int'(reg_addr), int'(mptr));
            $display("txn random write %0d: addr=%02h ptr=%02h bytes=%0d reg_addr=%02h", it, ab, ptr, nd, reg_addr);
         end else begin
            n = $urandom_range(1, 3);
            i2c_start();
            put_byte(8'h85, ack); check("rnd raddr ack", int'(ack), 0);
            for (int k = 0; k < n; k++) begin
               get_byte(d, k == n - 1);
               check("rnd read data", int'(d), int'(mptr ^ 8'hFF));
               mptr = mptr + 8'd1;
            end
            i2c_stop();
            check("rnd read no we", we_q.size() - wb, 0);
            check("rnd read reg_addr", int'(reg_addr), int'(mptr));
            $display("txn random read %0d: bytes=%0d reg_addr=%02h", it, n, reg_addr);
         end
         check("rnd busy idle", int'(busy), 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mak8_i2c_target.md
Name: mak8_i2c_target

Overview:
- I2C target (responder) that lets an external I2C initiator (Pmod/USB-I2C debug dongle, or a second board running our I2C master) read and write an 8-bit-addressed register space inside the MAK-8 system.
- It is the bus-side counterpart to our I2C initiator.
- It sits beside the CPU in the Nexys top level and exposes a simple register-port (addr/wdata/we/rdata) to the parent, which maps debug registers, PC and mailbox registers.
- SCL is input only: no clock stretching.

Parameters:
- DEV_ADDR, 7'h42, 7-bit target address matched after START.
- SYNC_STAGES, 2, synchronizer depth on scl_in/sda_in (minimum 2).

Ports:
- clk  in  1  system clock (100 MHz); must be ≥20× SCL frequency.
- rst_n  in  1  asynchronous active-low reset.
- scl_in  in  1  raw SCL pin level.
- sda_in  in  1  raw SDA pin level.
- sda_oe  out  1  1 = pull SDA low (open-drain); parent ties pad to 1'bz when 0.
- reg_addr  out  8  current register pointer.
- reg_wdata  out  8  last received write byte.
- reg_we  out  1  one-clk write strobe; reg_addr/reg_wdata valid in same cycle.
- reg_rdata  in  8  read data for reg_addr; parent returns it combinationally or from registers, stable within 1 clk.
- busy  out  1  high from address-matched ACK until STOP/NACK/mismatch.

Behaviour:
- Reset (async, rst_n=0):
  - sda_oe=0, reg_we=0, busy=0, reg_addr=8'h00, reg_wdata=8'h00.
  - FSM=IDLE; synchronizer flops reset to 1.
- Input conditioning:
  - scl/sda go through SYNC_STAGES flops plus one history flop.
  - Edge/condition detection latency is SYNC_STAGES+1 clks after a pin change.
- Bus conditions, evaluated on synced signals:
  - START: sda falls while scl=1.
  - STOP: sda rises while scl=1.
  - Both take priority over bit processing in every state.
- Bit timing:
  - Receive: sample sda on SCL rising edge, MSB first.
  - Transmit/ACK: change sda_oe only on SCL falling edge.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE.
- START (any state, including repeated START) → ADDR: bit counter cleared, sda_oe=0.
- STOP (any state) → IDLE: sda_oe=0, busy=0.
- ADDR, after 8 bits:
  - Address match → ADDR_ACK.
  - Mismatch → IGNORE, no ACK; IGNORE waits for START/STOP.
- ADDR_ACK:
  - On the falling edge after bit 8, set sda_oe=1 and busy=1.
  - On the next falling edge:
    - Write (R/W=0): release SDA, → PTR.
    - Read (R/W=1): capture reg_rdata into shift register, drive bit7 (sda_oe = ~bit), → RDATA.
- PTR:
  - First written byte loads reg_addr on 8th rising edge → PTR_ACK (ACK driven as above) → WDATA.
- WDATA:
  - On 8th rising edge: reg_wdata=byte, reg_we=1 for exactly 1 clk → WDATA_ACK.
  - reg_addr increments on the clk after reg_we.
  - WDATA_ACK drives ACK, then → WDATA. Bytes are unlimited.
- RDATA:
  - Shift out on each falling edge; after 8th bit, release SDA on the falling edge → RACK.
  - RACK samples the initiator's ACK on the rising edge and increments reg_addr.
  - ACK (0): on next falling edge capture reg_rdata (new address) and drive bit7 → RDATA.
  - NACK (1): → IGNORE, busy=0.
- Pointer arithmetic: 8-bit modulo; 8'hFF+1 → 8'h00.
- STOP/START mid-byte:
  - Partial byte discarded, no reg_we, reg_addr unchanged.
  - A completed pointer value persists across transactions (a read after write-pointer + repeated START uses it).
- sda_oe is never asserted in IDLE or IGNORE, or while scl=1 except the held ACK/data bit.

Test Plan:
- Write burst: START, 0x84, 0x10, 0xA5, 0x3C, STOP.
  - ACK on all 4 bytes.
  - reg_we pulses twice: (addr 0x10, data 0xA5), then (0x11, 0x3C).
  - reg_addr=0x12 after; busy low after STOP.
- Combined read: START, 0x84, 0x20, repeated START, 0x85, read 2 bytes (ACK, then NACK), STOP, with parent returning reg_rdata=reg_addr^8'hFF.
  - SDA carries 0xDF then 0xDE.
  - No reg_we pulses; reg_addr=0x22.
- Address mismatch: START, 0x90, 0x55, STOP.
  - sda_oe never asserts, busy stays 0, no reg_we.
- Pointer wrap: write pointer 0xFF, data 0x11, 0x22.
  - reg_we at 0xFF (0x11), then 0x00 (0x22); reg_addr=0x01.
- Abort: START, 0x84, 0x30, 4 bits of data, then STOP.
  - No reg_we, reg_addr=0x30, sda_oe=0, FSM IDLE.
  - A following full write to 0x84 behaves normally.
- Async reset mid-read (rst_n low while driving a 0 bit):
  - sda_oe drops to 0 immediately without a clk edge; reg_addr=0x00.
  - After release, the target ignores bus traffic until the next START.
